// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle read.
module fifo_sync_param #(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AFULL_TH  = 12,
    parameter  int AEMPTY_TH = 2,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, underflow_q;
    logic              rd_acc, wr_acc;

    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc  = rd_en && !empty;
        wr_acc  = wr_en && (!full || rd_acc);
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    // Storage is not reset, but a write in a reset cycle must not land.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) mem_q[wr_ptr_q] <= din;
    end

`ifdef FIFO_FWFT_EN
    assign dout = mem_q[rd_ptr_q];
`else
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (!rst)        dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param at DEPTH=4: vector table plus queue-based reference.
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk, rst, wr_en, rd_en;
    logic [DW-1:0] din, dout;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]    count;

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            cnt;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_dout;
    int            n_pass = 0;
    int            n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // One clock: drive, step the reference model, compare everything after the edge.
    task automatic step(input logic rs, input logic w, input logic r, input logic [DW-1:0] d,
                        input string tag);
        logic racc, wacc;
        rst = rs; wr_en = w; rd_en = r; din = d;
        racc = r && (mq.size() != 0);
        wacc = w && ((mq.size() != DP) || racc);
        @(posedge clk); #1;
        if (!rs) begin
            mq.delete();
            exp_dout = '0;
        end else begin
            if (racc) exp_dout = mq.pop_front();
            if (wacc) mq.push_back(d);
        end
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, " full"}, 32'(full), 32'(mq.size() == DP));
        chk({tag, " afull"}, 32'(almost_full), 32'(mq.size() >= 3));
        chk({tag, " aempty"}, 32'(almost_empty), 32'(mq.size() <= 1));
        chk({tag, " ovf"}, 32'(overflow), 32'(rs && w && !wacc));
        chk({tag, " udf"}, 32'(underflow), 32'(rs && r && !racc));
`ifdef FIFO_FWFT_EN
        if (mq.size() != 0) chk({tag, " dout"}, 32'(dout), 32'(mq[0]));
`else
        chk({tag, " dout"}, 32'(dout), 32'(exp_dout));
`endif
    endtask

    initial begin
        clk = 0; rst = 0; wr_en = 0; rd_en = 0; din = '0; exp_dout = '0;
        @(negedge clk);

        // Reset with a pending write: nothing may be stored.
        step(0, 1, 0, 8'hFF, "rst0");
        step(0, 1, 0, 8'hFF, "rst1");
        step(1, 0, 1, 8'h00, "post_rst_rd");

        vecs.push_back('{1, 0, 8'hA1, 1, 0, 0});
        vecs.push_back('{1, 0, 8'hB2, 2, 0, 0});
        vecs.push_back('{1, 0, 8'hC3, 3, 0, 0});
        vecs.push_back('{1, 0, 8'hD4, 4, 0, 0});
        vecs.push_back('{1, 0, 8'hEE, 4, 1, 0});
        vecs.push_back('{0, 1, 8'h00, 3, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 2, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 1, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 0, 0, 1});
        vecs.push_back('{1, 0, 8'h11, 1, 0, 0});
        vecs.push_back('{1, 0, 8'h22, 2, 0, 0});
        vecs.push_back('{1, 0, 8'h33, 3, 0, 0});
        vecs.push_back('{1, 0, 8'h44, 4, 0, 0});
        vecs.push_back('{1, 1, 8'h55, 4, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 3, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 2, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 1, 0, 0});
        vecs.push_back('{0, 1, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 1, 8'h66, 1, 0, 1});
        vecs.push_back('{0, 1, 8'h00, 0, 0, 0});

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            step(1, vecs[i].w, vecs[i].r, vecs[i].d, nm);
            chk({nm, " tbl_cnt"}, 32'(count), 32'(vecs[i].cnt));
            chk({nm, " tbl_ovf"}, 32'(overflow), 32'(vecs[i].ovf));
            chk({nm, " tbl_udf"}, 32'(underflow), 32'(vecs[i].udf));
        end

        // Wrap-around: 10 words through a 4-deep FIFO with simultaneous push/pop.
        step(1, 1, 0, 8'h00, "wrap_w0");
        for (int i = 1; i < 10; i++) step(1, 1, 1, 8'(i), $sformatf("wrap%0d", i));
        step(1, 0, 1, 8'h00, "wrap_last");
        chk("wrap_tail dout", 32'(dout), 32'h09);

        // Reset mid-operation discards contents.
        step(1, 1, 0, 8'h77, "mid_w0");
        step(1, 1, 0, 8'h78, "mid_w1");
        step(0, 0, 0, 8'h00, "mid_rst");
        step(1, 0, 1, 8'h00, "mid_rd");

`ifdef FIFO_FWFT_EN
        step(1, 1, 0, 8'h5A, "fwft_w");
        chk("fwft head", 32'(dout), 32'h5A);
        step(1, 0, 0, 8'h00, "fwft_hold");
        step(1, 0, 1, 8'h00, "fwft_pop");
        chk("fwft empty", 32'(empty), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
